// File: rtl/noc_pkg.sv
// noc_pkg: shared types and defaults for the NoC router arbitration logic.
//   NOC_REN / NOC_PL : default requester count and flit payload width
//   flit_t           : flit payload plus tail marker
//   arb_state_e      : packet-lock state of an output arbiter
//   wrap_inc         : modulo increment for port indices (any port count)
package noc_pkg;

  localparam int NOC_REN = 5;
  localparam int NOC_PL  = 8;

  typedef struct packed {
    logic [NOC_PL-1:0] data;
    logic              last;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Next index after idx in a ring of n entries; n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: combinational request picker, shared with the VC allocator.
//   req_i     : per-port request vector
//   ptr_i     : round-robin start index (ignored in fixed mode)
//   mode_i    : 1 = round-robin from ptr_i, 0 = lowest index wins
//   gnt_idx_o : chosen index (0 when nothing is requested)
//   gnt_any_o : at least one request present
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int REN = NOC_REN
) (
  input  logic [REN-1:0]         req_i,
  input  logic [$clog2(REN)-1:0] ptr_i,
  input  logic                   mode_i,
  output logic [$clog2(REN)-1:0] gnt_idx_o,
  output logic                   gnt_any_o
);

  localparam int          IDX_W = $clog2(REN);
  localparam int unsigned RENU  = REN;

  int unsigned      start_s;
  int unsigned      cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             found_s;

  // Scan upward from the start index with explicit wrap; first hit wins.
  always_comb begin
    gnt_any_o  = |req_i;
    gnt_idx_o  = '0;
    found_s    = 1'b0;
    cand_s     = 32'd0;
    cand_idx_s = '0;
    start_s    = mode_i ? 32'(ptr_i) : 32'd0;
    for (int unsigned k = 0; k < RENU; k++) begin
      cand_s     = (start_s + k >= RENU) ? (start_s + k - RENU) : (start_s + k);
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && req_i[cand_idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_o = cand_idx_s;
      end else begin
        found_s   = found_s;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: N-to-1 wormhole packet arbiter for a router output port.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/valid/last  : per-port flit, valid and tail marker
//   in_ready            : per-port accept (combinational grant)
//   out_data/valid/last : registered granted flit
//   out_port            : source port of the flit in out_data
//   out_ready           : downstream accept
// A packet whose head is granted keeps the output until its tail transfers.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int REN     = NOC_REN,
  parameter int PL      = NOC_PL,
  parameter int RR_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REN-1:0][PL-1:0] in_data,
  input  logic [REN-1:0]         in_valid,
  input  logic [REN-1:0]         in_last,
  output logic [REN-1:0]         in_ready,
  output logic [PL-1:0]          out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [$clog2(REN)-1:0] out_port,
  input  logic                   out_ready
);

  localparam int          IDX_W = $clog2(REN);
  localparam int unsigned RENU  = REN;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PL-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] out_port_q, out_port_d;

  logic             slot_free_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_req_s;
  logic             sel_gate_s;
  logic             xfer_s;
  logic             sel_last_s;

  noc_rr_pick #(.REN(REN)) u_pick (
    .req_i     (in_valid),
    .ptr_i     (rr_ptr_q),
    .mode_i    (RR_MODE != 0),
    .gnt_idx_o (pick_idx_s),
    .gnt_any_o (pick_any_s)
  );

  // Grant selection, handshake, lock FSM and output register next state.
  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_port_d  = out_port_q;
    in_ready    = '0;

    slot_free_s = !out_valid_q || out_ready;

    // While locked the owner keeps ready even through a bubble.
    if (state_q == LOCKED) begin
      sel_idx_s  = lock_idx_q;
      sel_req_s  = in_valid[lock_idx_q];
      sel_gate_s = 1'b1;
    end else begin
      sel_idx_s  = pick_idx_s;
      sel_req_s  = pick_any_s;
      sel_gate_s = pick_any_s;
    end

    sel_last_s = in_last[sel_idx_s];
    xfer_s     = !rst && slot_free_s && sel_req_s;

    if (!rst && slot_free_s && sel_gate_s) begin
      in_ready[sel_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end

    if (xfer_s) begin
      out_data_d  = in_data[sel_idx_s];
      out_last_d  = sel_last_s;
      out_port_d  = sel_idx_s;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (xfer_s && !sel_last_s) begin
          state_d    = LOCKED;
          lock_idx_d = sel_idx_s;
        end else if (xfer_s) begin
          rr_ptr_d = IDX_W'(wrap_inc(32'(sel_idx_s), RENU));
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && sel_last_s) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(32'(sel_idx_s), RENU));
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset drops any lock and held flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_port_q  <= out_port_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_port  = out_port_q;

endmodule
